// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges ALU and load writeback FIFOs onto the single
// registered register-file write port. Define WB_ZERO_DROP_EN to make register 0 read-only.
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_add,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [DATA_W-1:0] ld_data,
    output logic [1:0]        reg_en,
    output logic [ADDR_W-1:0] reg_add,
    output logic [DATA_W-1:0] reg_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NSRC  = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;

    logic [ADDR_W-1:0] mem_add  [NSRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NSRC];
    logic [PTR_W-1:0]  rd_ptr   [NSRC];
    logic [CNT_W-1:0]  count    [NSRC];
    logic [ADDR_W-1:0] in_add   [NSRC];
    logic [DATA_W-1:0] in_data  [NSRC];

    logic [NSRC-1:0]   in_valid;
    logic [NSRC-1:0]   full;
    logic [NSRC-1:0]   nonempty;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;

    src_t              last_grant;
    src_t              grant_src;
    logic              grant;
    logic              sel;
    logic              emit;
    logic [ADDR_W-1:0] head_add;
    logic [DATA_W-1:0] head_data;

    assign in_valid   = {ld_valid, alu_valid};
    assign in_add[0]  = alu_add;
    assign in_add[1]  = ld_add;
    assign in_data[0] = alu_data;
    assign in_data[1] = ld_data;

    assign alu_ready = !full[0] && !reset;
    assign ld_ready  = !full[1] && !reset;

    // Push acceptance looks only at the registered full flag, never at a same-cycle pop.
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            full[s]     = (count[s] == CNT_W'(FIFO_DEPTH));
            nonempty[s] = (count[s] != '0);
            push[s]     = in_valid[s] && !full[s] && !reset;
        end
    end

    always_comb begin
        grant     = 1'b0;
        grant_src = SRC_ALU;
        if (nonempty[0] && nonempty[1]) begin
            grant     = 1'b1;
            grant_src = (last_grant == SRC_ALU) ? SRC_LD : SRC_ALU;
        end else if (nonempty[0]) begin
            grant     = 1'b1;
            grant_src = SRC_ALU;
        end else if (nonempty[1]) begin
            grant     = 1'b1;
            grant_src = SRC_LD;
        end

        sel       = (grant_src == SRC_LD);
        pop       = '0;
        pop[0]    = grant && (grant_src == SRC_ALU);
        pop[1]    = grant && (grant_src == SRC_LD);
        head_add  = mem_add[sel][rd_ptr[sel]];
        head_data = mem_data[sel][rd_ptr[sel]];

`ifdef WB_ZERO_DROP_EN
        emit = grant && (head_add != '0);
`else
        emit = grant;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                if (push[s] && !pop[s])
                    count[s] <= count[s] + CNT_W'(1);
                else if (!push[s] && pop[s])
                    count[s] <= count[s] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem_add[s][wr_ptr[s]]  <= in_add[s];
                mem_data[s][wr_ptr[s]] <= in_data[s];
            end
        end
    end

    // A dropped zero-address entry still counts as a grant for round-robin fairness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_en     <= '0;
            reg_add    <= '0;
            reg_data   <= '0;
            last_grant <= SRC_LD;
        end else begin
            if (grant) last_grant <= grant_src;
            if (emit) begin
                reg_en   <= {grant_src == SRC_LD, 1'b1};
                reg_add  <= head_add;
                reg_data <= head_data;
            end else begin
                reg_en   <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (FIFO_DEPTH=2, DATA_W=16, ADDR_W=3);
// honours WB_ZERO_DROP_EN when defined.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_add;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_add;
    logic [15:0] ld_data;
    logic [1:0]  reg_en;
    logic [2:0]  reg_add;
    logic [15:0] reg_data;

    int checks;
    int failures;

    regfile_wb_arbiter #(
        .FIFO_DEPTH(2),
        .DATA_W    (16),
        .ADDR_W    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_add  (alu_add),
        .alu_data (alu_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_add   (ld_add),
        .ld_data  (ld_data),
        .reg_en   (reg_en),
        .reg_add  (reg_add),
        .reg_data (reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic [1:0] en, input logic [2:0] add,
                            input logic [15:0] data);
        chk({tag, "_en"},   32'(reg_en),   32'(en));
        chk({tag, "_add"},  32'(reg_add),  32'(add));
        chk({tag, "_data"}, 32'(reg_data), 32'(data));
    endtask

    initial begin
        logic acc_a;
        logic acc_l;
        int   na;
        int   nl;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_add   = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_add    = '0;
        ld_data   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_port("rst", 2'b00, 3'd0, 16'h0000);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_ld_ready",  32'(ld_ready),  32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_rst_ld_ready",  32'(ld_ready),  32'd1);

        // 1: single ALU write
        alu_valid = 1'b1; alu_add = 3'd3; alu_data = 16'h1234;
        step();
        chk("t1_accept_en", 32'(reg_en), 32'd0);
        alu_valid = 1'b0;
        step();
        chk_port("t1_write", 2'b01, 3'd3, 16'h1234);
        step();
        chk_port("t1_idle", 2'b00, 3'd3, 16'h1234);

        // 2: simultaneous requests just after reset -> ALU first
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_port("t2_rst", 2'b00, 3'd0, 16'h0000);
        alu_valid = 1'b1; alu_add = 3'd1; alu_data = 16'hAAAA;
        ld_valid  = 1'b1; ld_add  = 3'd2; ld_data  = 16'h5555;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("t2_accept_en", 32'(reg_en), 32'd0);
        step();
        chk_port("t2_alu", 2'b01, 3'd1, 16'hAAAA);
        step();
        chk_port("t2_ld", 2'b11, 3'd2, 16'h5555);
        step();
        chk("t2_idle_en", 32'(reg_en), 32'd0);

        // 3: four back-to-back ALU writes
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_add   = 3'(i + 4);
            alu_data  = 16'hC000 + 16'(i);
            chk("t3_alu_ready", 32'(alu_ready), 32'd1);
            step();
            if (i > 0) chk_port("t3_stream", 2'b01, 3'(i + 3), 16'hC000 + 16'(i - 1));
        end
        alu_valid = 1'b0;
        step();
        chk_port("t3_last", 2'b01, 3'd7, 16'hC003);
        step();
        chk("t3_idle_en", 32'(reg_en), 32'd0);

        // 4: both sources stream; grants alternate LD,ALU,... starting at edge 2
        na = 0;
        nl = 0;
        alu_add = 3'd1;
        ld_add  = 3'd2;
        for (int k = 1; k <= 13; k++) begin
            alu_valid = (k <= 10);
            ld_valid  = (k <= 10);
            alu_data  = 16'hA000 + 16'(na);
            ld_data   = 16'hB000 + 16'(nl);
            acc_a     = alu_valid && alu_ready;
            acc_l     = ld_valid && ld_ready;
            step();
            if (acc_a) na++;
            if (acc_l) nl++;
            if (k == 1)
                chk("t4_first_en", 32'(reg_en), 32'd0);
            else if (k % 2 == 0)
                chk_port("t4_ld", 2'b11, 3'd2, 16'hB000 + 16'((k - 2) / 2));
            else
                chk_port("t4_alu", 2'b01, 3'd1, 16'hA000 + 16'((k - 3) / 2));
            if (k >= 2 && k <= 10) chk("t4_alu_ready", 32'(alu_ready), 32'(k % 2));
            if (k >= 3 && k <= 10) chk("t4_ld_ready",  32'(ld_ready),  32'((k + 1) % 2));
        end
        step();
        chk("t4_idle_en", 32'(reg_en), 32'd0);
        chk("t4_alu_accepted", 32'(na), 32'd6);
        chk("t4_ld_accepted",  32'(nl), 32'd6);

        // 5: fill both FIFOs then reset mid-operation
        alu_valid = 1'b1; alu_add = 3'd4; alu_data = 16'hC0DE;
        ld_valid  = 1'b1; ld_add  = 3'd6; ld_data  = 16'hD00D;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk_port("t5_rst", 2'b00, 3'd0, 16'h0000);
        chk("t5_rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("t5_rst_ld_ready",  32'(ld_ready),  32'd0);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        chk("t5_ld_ready",  32'(ld_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_port("t5_no_stale", 2'b00, 3'd0, 16'h0000);
        end

        // 6: write to register 0
        alu_valid = 1'b1; alu_add = 3'd0; alu_data = 16'hFFFF;
        step();
        alu_valid = 1'b0;
        step();
`ifdef WB_ZERO_DROP_EN
        chk_port("t6_zero", 2'b00, 3'd0, 16'h0000);
`else
        chk_port("t6_zero", 2'b01, 3'd0, 16'hFFFF);
`endif
        alu_valid = 1'b1; alu_add = 3'd5; alu_data = 16'h0505;
        step();
        alu_valid = 1'b0;
        step();
        chk_port("t6_next", 2'b01, 3'd5, 16'h0505);
        step();
        chk("t6_idle_en", 32'(reg_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
